sfx_sequencer: RTL and testbench

//  Upstream feeder of note_gen: turns game-event toggles from the pclk domain into timed note sequences.

---
 rtl/sfx_pkg.sv | 62 ++++++
 rtl/toggle_sync.sv | 32 +++
 rtl/sfx_sequencer.sv | 152 +++++++++++++++
 tb/tb_sfx_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfx_pkg: note codes, dividers, sequence ids and the step record layout.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package sfx_pkg;

  localparam int DIV_W = 22;
  localparam int DUR_W = 8;

  typedef enum logic [2:0] {
    NOTE_C4 = 3'd0,
    NOTE_D4 = 3'd1,
    NOTE_E4 = 3'd2,
    NOTE_G4 = 3'd3,
    NOTE_A4 = 3'd4
  } note_e;

  // Encoding doubles as priority: larger value pre-empts smaller.
  typedef enum logic [1:0] {
    SEQ_JUMP = 2'd0,
    SEQ_LAND = 2'd1,
    SEQ_CD   = 2'd2,
    SEQ_OVER = 2'd3
  } seq_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef struct packed {
    note_e              note;
    logic [DUR_W-1:0]   dur;
    logic               last;
  } step_t;

  localparam logic [DIV_W-1:0] DIV_SILENCE = 22'd1;
  localparam logic [DIV_W-1:0] DIV_C4      = 22'd190839;
  localparam logic [DIV_W-1:0] DIV_D4      = 22'd170068;
  localparam logic [DIV_W-1:0] DIV_E4      = 22'd151515;
  localparam logic [DIV_W-1:0] DIV_G4      = 22'd127551;
  localparam logic [DIV_W-1:0] DIV_A4      = 22'd113636;

  function automatic logic [DIV_W-1:0] div_of(input note_e n);
    logic [DIV_W-1:0] d;
    d = DIV_SILENCE;
    case (n)
      NOTE_C4: d = DIV_C4;
      NOTE_D4: d = DIV_D4;
      NOTE_E4: d = DIV_E4;
      NOTE_G4: d = DIV_G4;
      NOTE_A4: d = DIV_A4;
      default: d = DIV_SILENCE;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toggle_sync: two-flop synchroniser with change detect (one-clk pulse).      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tgl,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_tgl;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfx_sequencer: game-event toggles -> prioritised, timed note sequences.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 500_000,
  parameter int unsigned GAP_TICKS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_tgl,
  input  logic        land_tgl,
  input  logic        cd_tgl,
  input  logic [2:0]  cd_code,
  input  logic        over_tgl,
  input  logic        mute,
  output logic [21:0] note_div,
  output logic        busy
);

  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_PRELAST = TICK_W'(TICK_CYCLES - 2);
  localparam logic [DUR_W-1:0]  GAP_DUR      = DUR_W'(GAP_TICKS);

  state_e              r_state;
  state_e              w_next_state;
  seq_e                r_seq;
  seq_e                w_ev_seq;
  logic [1:0]          r_step;
  logic [2:0]          r_cd_code;
  logic [TICK_W-1:0]   r_tick;
  logic [DUR_W-1:0]    r_dur;
  logic [DIV_W-1:0]    r_note_div;
  step_t               w_step;
  logic [3:0]          w_tgl;
  logic [3:0]          w_ev;
  logic                w_ev_any;
  logic                w_accept;
  logic                w_tick;
  logic                w_play_end;
  logic                w_gap_end;

  // Bit index of each toggle equals its sequence priority.
  assign w_tgl = {over_tgl, cd_tgl, land_tgl, jump_tgl};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    toggle_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_tgl   (w_tgl[gi]),
      .o_pulse (w_ev[gi])
    );
  end

  always_comb begin
    w_ev_seq = SEQ_JUMP;
    if (w_ev[3])      w_ev_seq = SEQ_OVER;
    else if (w_ev[2]) w_ev_seq = SEQ_CD;
    else if (w_ev[1]) w_ev_seq = SEQ_LAND;
  end

  assign w_ev_any = |w_ev;
  assign w_accept = w_ev_any && !mute && ((r_state == ST_IDLE) || (w_ev_seq >= r_seq));
  assign w_tick   = (r_tick == TICK_LAST);

  always_comb begin
    w_step = '{note: NOTE_C4, dur: 8'd20, last: 1'b1};
    case ({r_seq, r_step})
      {SEQ_OVER, 2'd0}: w_step = '{note: NOTE_E4, dur: 8'd40, last: 1'b0};
      {SEQ_OVER, 2'd1}: w_step = '{note: NOTE_D4, dur: 8'd40, last: 1'b0};
      {SEQ_OVER, 2'd2}: w_step = '{note: NOTE_C4, dur: 8'd80, last: 1'b1};
      {SEQ_CD,   2'd0}: begin
        case (r_cd_code)
          3'd2:    w_step = '{note: NOTE_D4, dur: 8'd32, last: 1'b1};
          3'd1:    w_step = '{note: NOTE_E4, dur: 8'd32, last: 1'b1};
          3'd0:    w_step = '{note: NOTE_G4, dur: 8'd64, last: 1'b1};
          default: w_step = '{note: NOTE_C4, dur: 8'd32, last: 1'b1};
        endcase
      end
      {SEQ_LAND, 2'd0}: w_step = '{note: NOTE_A4, dur: 8'd20, last: 1'b1};
      default:          w_step = '{note: NOTE_C4, dur: 8'd20, last: 1'b1};
    endcase
  end

  assign w_play_end = (r_state == ST_PLAY) && w_tick && (r_dur == 8'd1);
  // Leave GAP one clk early: the LOAD cycle completes the final gap tick.
  assign w_gap_end  = (r_state == ST_GAP) && (r_dur == 8'd1) && (r_tick == TICK_PRELAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (mute) begin
      w_next_state = ST_IDLE;
    end else if (w_accept) begin
      w_next_state = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_IDLE;
        ST_LOAD: w_next_state = ST_PLAY;
        ST_PLAY: if (w_play_end) w_next_state = w_step.last ? ST_IDLE : ST_GAP;
        ST_GAP:  if (w_gap_end)  w_next_state = ST_LOAD;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    note_div = r_note_div;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq      <= SEQ_JUMP;
      r_step     <= 2'd0;
      r_cd_code  <= 3'd0;
      r_tick     <= '0;
      r_dur      <= '0;
      r_note_div <= DIV_SILENCE;
    end else begin
      if (w_ev[2]) r_cd_code <= cd_code;

      if (w_accept) begin
        r_seq  <= w_ev_seq;
        r_step <= 2'd0;
      end else if (w_gap_end) begin
        r_step <= r_step + 2'd1;
      end

      if ((r_state == ST_LOAD) || w_tick) r_tick <= '0;
      else                                r_tick <= r_tick + 1'b1;

      if (r_state == ST_LOAD)            r_dur <= w_step.dur;
      else if (w_play_end)               r_dur <= GAP_DUR;
      else if (w_tick && (r_dur != '0))  r_dur <= r_dur - 1'b1;

      if (mute)                    r_note_div <= DIV_SILENCE;
      else if (r_state == ST_LOAD) r_note_div <= div_of(w_step.note);
      else if (w_play_end)         r_note_div <= DIV_SILENCE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sfx_sequencer: directed + random stimulus against a timeline model.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sfx_sequencer;

  localparam int TC = 4;
  localparam int GT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_tgl = 1'b0;
  logic        land_tgl = 1'b0;
  logic        cd_tgl = 1'b0;
  logic        over_tgl = 1'b0;
  logic        mute = 1'b0;
  logic [2:0]  cd_code = 3'd0;
  logic [21:0] note_div;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit [3:0] pend [int];
  int       pend_code [int];
  int       last_flip [4] = '{-100, -100, -100, -100};

  bit act_v = 0;
  int act_seq = 0, act_code = 0, act_L = 0;
  bit old_v = 0;
  int old_seq = 0, old_code = 0, old_L = 0;

  sfx_sequencer #(.TICK_CYCLES(TC), .GAP_TICKS(GT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .jump_tgl (jump_tgl),
    .land_tgl (land_tgl),
    .cd_tgl   (cd_tgl),
    .cd_code  (cd_code),
    .over_tgl (over_tgl),
    .mute     (mute),
    .note_div (note_div),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Notes: 0=C4 1=D4 2=E4 3=G4 4=A4
  function automatic logic [21:0] div_of(input int n);
    case (n)
      0: return 22'd190839;
      1: return 22'd170068;
      2: return 22'd151515;
      3: return 22'd127551;
      4: return 22'd113636;
      default: return 22'd1;
    endcase
  endfunction

  // Output at offset k clk after the first note of a sequence becomes valid.
  function automatic void tl(input int seq, input int code, input int k,
                             output logic [21:0] n, output bit b);
    int nts[3];
    int drs[3];
    int cnt;
    int pos;
    nts = '{0, 0, 0};
    drs = '{20, 0, 0};
    cnt = 1;
    case (seq)
      3: begin nts = '{2, 1, 0}; drs = '{40, 40, 80}; cnt = 3; end
      2: begin
        case (code)
          3: begin nts[0] = 0; drs[0] = 32; end
          2: begin nts[0] = 1; drs[0] = 32; end
          1: begin nts[0] = 2; drs[0] = 32; end
          default: begin nts[0] = 3; drs[0] = 64; end
        endcase
      end
      1: begin nts[0] = 4; drs[0] = 20; end
      default: begin nts[0] = 0; drs[0] = 20; end
    endcase
    n = 22'd1;
    b = 1'b0;
    pos = 0;
    if (k < 0) begin
      b = 1'b1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      if (k < pos + drs[i] * TC) begin
        n = div_of(nts[i]);
        b = 1'b1;
        return;
      end
      pos += drs[i] * TC;
      if (i == cnt - 1) return;
      if (k < pos + GT * TC) begin
        b = 1'b1;
        return;
      end
      pos += GT * TC;
    end
  endfunction

  function automatic bit busy_at(input int c);
    logic [21:0] n;
    bit b;
    if (!act_v) return 1'b0;
    if (c == act_L) return 1'b1;
    tl(act_seq, act_code, c - act_L - 1, n, b);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic flip(input int which);
    int e;
    e = cyc + 3;
    if (pend.exists(e)) pend[e] = pend[e] | (4'b1 << which);
    else                pend[e] = 4'b1 << which;
    if (which == 2) pend_code[e] = int'(cd_code);
    case (which)
      0: jump_tgl = ~jump_tgl;
      1: land_tgl = ~land_tgl;
      2: cd_tgl   = ~cd_tgl;
      default: over_tgl = ~over_tgl;
    endcase
    last_flip[which] = cyc;
  endtask

  task automatic cycle();
    bit          bprev;
    bit          eb;
    logic [21:0] en;
    int          hi;
    @(posedge clk);
    cyc++;
    bprev = busy_at(cyc - 1);
    if (mute) begin
      act_v = 0;
      old_v = 0;
    end else if (pend.exists(cyc)) begin
      hi = 0;
      if (pend[cyc][3])      hi = 3;
      else if (pend[cyc][2]) hi = 2;
      else if (pend[cyc][1]) hi = 1;
      if (!bprev || hi >= act_seq) begin
        old_v = act_v; old_seq = act_seq; old_code = act_code; old_L = act_L;
        act_v = 1; act_seq = hi; act_L = cyc;
        act_code = (hi == 2) ? pend_code[cyc] : 0;
      end
    end
    if (pend.exists(cyc)) pend.delete(cyc);
    if (pend_code.exists(cyc)) pend_code.delete(cyc);
    @(negedge clk);
    en = 22'd1;
    eb = 1'b0;
    if (act_v && cyc == act_L) begin
      eb = 1'b1;
      if (old_v) tl(old_seq, old_code, cyc - old_L - 1, en, bprev);
    end else if (act_v) begin
      tl(act_seq, act_code, cyc - act_L - 1, en, eb);
    end
    chk("model_note", note_div, en);
    chk("model_busy", 22'(busy), 22'(eb));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) cycle();
  endtask

  initial begin
    int f;
    int f2;
    int r;
    int w;

    repeat (4) @(negedge clk);
    chk("rst_note", note_div, 22'd1);
    chk("rst_busy", 22'(busy), 22'd0);
    rst_n = 1'b1;
    run_to(1000);
    chk("idle_note", note_div, 22'd1);
    chk("idle_busy", 22'(busy), 22'd0);

    // Jump
    f = cyc;
    flip(0);
    run_to(f + 3);
    chk("jump_pre", note_div, 22'd1);
    cycle();
    chk("jump_start", note_div, 22'd190839);
    chk("jump_busy", 22'(busy), 22'd1);
    run_to(f + 83);
    chk("jump_hold", note_div, 22'd190839);
    cycle();
    chk("jump_end", note_div, 22'd1);
    chk("jump_end_busy", 22'(busy), 22'd0);
    run_to(f + 120);

    // Game over
    f = cyc;
    flip(3);
    run_to(f + 4);
    chk("over_s0", note_div, 22'd151515);
    run_to(f + 4 + 160);
    chk("over_gap0", note_div, 22'd1);
    chk("over_gap0_busy", 22'(busy), 22'd1);
    run_to(f + 4 + 167);
    chk("over_gap0_last", note_div, 22'd1);
    cycle();
    chk("over_s1", note_div, 22'd170068);
    run_to(f + 4 + 336);
    chk("over_s2", note_div, 22'd190839);
    run_to(f + 4 + 656);
    chk("over_end", note_div, 22'd1);
    chk("over_end_busy", 22'(busy), 22'd0);
    run_to(f + 700);

    // Pre-emption
    f = cyc;
    flip(0);
    run_to(f + 30);
    f2 = cyc;
    flip(3);
    run_to(f2 + 3);
    chk("pre_load", note_div, 22'd190839);
    cycle();
    chk("pre_switch", note_div, 22'd151515);
    run_to(f2 + 20);
    flip(0);
    run_to(f2 + 40);
    chk("pre_jump_ignored", note_div, 22'd151515);
    run_to(f2 + 4 + 700);

    // Simultaneous land + countdown code 1
    cd_code = 3'd1;
    f = cyc;
    flip(1);
    flip(2);
    run_to(f + 4);
    chk("sim_start", note_div, 22'd151515);
    run_to(f + 4 + 127);
    chk("sim_hold", note_div, 22'd151515);
    cycle();
    chk("sim_end", note_div, 22'd1);
    chk("sim_end_busy", 22'(busy), 22'd0);
    run_to(f + 200);

    // Mute during game-over step 2
    f = cyc;
    flip(3);
    run_to(f + 4 + 376);
    chk("mute_pre", note_div, 22'd190839);
    mute = 1'b1;
    cycle();
    chk("mute_note", note_div, 22'd1);
    chk("mute_busy", 22'(busy), 22'd0);
    flip(0);
    run_to(cyc + 10);
    chk("mute_drop", note_div, 22'd1);
    mute = 1'b0;
    run_to(cyc + 20);
    chk("mute_after", 22'(busy), 22'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        w = $urandom_range(0, 3);
        if (cyc - last_flip[w] > 3) begin
          if (w == 2) cd_code = 3'($urandom_range(0, 3));
          flip(w);
        end
      end else if (r == 50) begin
        mute = 1'b1;
      end else if (r >= 95) begin
        mute = 1'b0;
      end
      cycle();
    end
    mute = 1'b0;
    run_to(cyc + 800);
    chk("final_busy", 22'(busy), 22'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
